rtype_mc_ctrl: RTL and testbench
================================

# rtype_mc_ctrl

Multi-cycle sequencer for the R-type RISC-V core. It fetches an instruction over a req/ack handshake and holds it in an internal instruction register. It then steps the decode/register-file stage, the ALU and writeback through fixed phases, producing register-file write enable, ALU operation and PC update strobes. It sits between instruction memory and the ID/EX datapath, replacing the single-cycle combinational control.

## Interface
Parameters:
- XLEN, 32, instruction/data width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_o  out  1  instruction fetch request; held until acknowledged.
- imem_ack_i  in  1  fetch acknowledge; imem_rdata_i valid in the same cycle.
- imem_rdata_i  in  32  fetched instruction word.
- instr_o  out  32  instruction register contents; drives rs1 [19:15], rs2 [24:20], rd [11:7] of the ID stage.
- alu_op_o  out  4  ALU operation code; valid in EXEC.
- alu_res_we_o  out  1  latch ALU result into the result register (EXEC).
- reg_wen_o  out  1  register-file write enable (WB, rd != 0).
- pc_we_o  out  1  PC <= PC + 4 strobe (WB).
- illegal_o  out  1  sticky illegal-instruction flag.
- busy_o  out  1  high in every state except FETCH-waiting and TRAP.

## Operation
- States: FETCH, DECODE, EXEC, WB, TRAP. Reset state is FETCH.
- FETCH:
  - imem_req_o = 1.
  - On imem_ack_i = 1, the IR captures imem_rdata_i and the FSM moves to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE:
  - Register file reads rs1/rs2 from instr_o.
  - A legal instruction goes to EXEC; an illegal one goes to TRAP.
- Legal instruction: opcode 7'b0110011 with a valid funct7/funct3 pair:
  - funct7 = 0000000: all funct3.
  - funct7 = 0100000: funct3 000 (SUB) or 101 (SRA).
  - Everything else is illegal.
- EXEC: alu_op_o is driven from the decode; alu_res_we_o = 1; next state is WB.
- WB:
  - reg_wen_o = 1 unless rd == 0.
  - pc_we_o = 1.
  - Next state is FETCH.
- TRAP: illegal_o = 1; the FSM stays in TRAP until rst. No strobes are asserted.
- alu_op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9. alu_op_o = 0 outside EXEC.
- All strobes are decoded from state (Moore) and are single-cycle per instruction.

## Timing
- Reset values:
  - state FETCH; IR 32'h0.
  - imem_req_o is 0 during the rst cycle and 1 from the first cycle after rst deasserts.
  - All other outputs 0.
- Minimum latency is 4 cycles per instruction (ack in the first FETCH cycle). Each cycle of ack delay adds one cycle.
- imem_req_o is held high until ack. imem_ack_i outside FETCH is ignored, and the IR is unchanged.
- instr_o is stable from DECODE through WB and changes only on an accepted fetch.
- If rst is asserted in any state, the FSM is in FETCH with all outputs at reset values on the next edge. A pending writeback is dropped.
- rst has priority over imem_ack_i arriving in the same cycle; the instruction is discarded.

## Configuration
- RTYPE_MC_CTRL_PERF_EN defined:
  - Adds outputs cycle_cnt_o[31:0] and instret_o[31:0], both reset to 0.
  - cycle_cnt_o increments every non-reset cycle.
  - instret_o increments on each WB cycle.
  - Both wrap from 32'hFFFF_FFFF to 0.
- Undefined: no counters and no extra ports.

## Structure
- Package rtype_ctrl_pkg holds:
  - the state enum;
  - alu_op localparams;
  - OPC_RTYPE;
  - funct7 constants F7_BASE and F7_ALT.
- Sub-module rtype_decoder is combinational. It maps instr[31:0] to {legal, alu_op}. The FSM stays in rtype_mc_ctrl.

## Test plan
- Reset, then 0x002081B3 (add x3,x1,x2) with ack on the first request cycle:
  - IR = 0x002081B3 in DECODE.
  - alu_op_o = 0 in EXEC.
  - reg_wen_o = 1 and pc_we_o = 1 in WB, on the 4th cycle.
  - imem_req_o = 1 again on the 5th cycle.
- 0x407302B3 (sub x5,x6,x7) -> alu_op_o = 1 in EXEC; reg_wen_o = 1 in WB.
- 0x00208033 (add x0,x1,x2) -> reg_wen_o = 0 and pc_we_o = 1 in WB.
- Ack delayed 3 cycles -> imem_req_o stays high for 4 cycles; the instruction completes in 7 cycles total. A spurious ack in EXEC leaves the IR unchanged.
- 0x00000013 (addi) -> TRAP after DECODE:
  - illegal_o = 1, held for 10+ cycles with no strobes.
  - rst clears it, and imem_req_o = 1 on the next cycle.
- rst asserted during EXEC -> reg_wen_o never asserts for that instruction. With PERF_EN, instret_o = 0 and cycle_cnt_o restarts from 0.

Source files
------------

// File: rtl/rtype_ctrl_pkg.sv
// Shared types and constants for the multi-cycle R-type sequencer:
// FSM state encoding, ALU operation codes and R-type opcode/funct7 values.
package rtype_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // Field extraction helpers so decode reads in instruction-format terms.
  function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [2:0] instr_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [6:0] instr_funct7(input logic [31:0] instr);
    return instr[31:25];
  endfunction

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: classifies an instruction word as a legal
// RV32I R-type ALU instruction and produces its ALU operation code.
module rtype_decoder
  import rtype_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output logic [3:0]  alu_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  // Register indices are consumed by the ID stage, not by decode.
  logic unused_fields;
  assign unused_fields = &{1'b0, instr[24:15], instr[11:7]};

  assign opcode = instr_opcode(instr);
  assign funct3 = instr_funct3(instr);
  assign funct7 = instr_funct7(instr);

  // Map funct7/funct3 to ALU op; anything outside the R-type table is illegal.
  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    if (opcode == OPC_RTYPE) begin
      if (funct7 == F7_BASE) begin
        legal = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        case (funct3)
          3'b000: begin
            legal  = 1'b1;
            alu_op = ALU_SUB;
          end
          3'b101: begin
            legal  = 1'b1;
            alu_op = ALU_SRA;
          end
          default: begin
            legal  = 1'b0;
            alu_op = ALU_ADD;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/rtype_mc_ctrl.sv
// Multi-cycle sequencer for the R-type core: fetches over a req/ack
// handshake into the instruction register, then steps DECODE, EXEC and WB,
// emitting Moore strobes for ALU result latch, register write and PC update.
// Illegal instructions park the FSM in TRAP until reset.
// Optional performance counters are enabled by RTYPE_MC_CTRL_PERF_EN.
//
// state  | meaning
// FETCH  | request instruction, capture IR on ack
// DECODE | register file reads rs1/rs2, legality check
// EXEC   | ALU operates, result register latched
// WB     | register write (rd != 0) and PC += 4
// TRAP   | illegal instruction seen, wait for reset
module rtype_mc_ctrl
  import rtype_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_res_we_o,
  output logic            reg_wen_o,
  output logic            pc_we_o,
  output logic            illegal_o,
  output logic            busy_o
`ifdef RTYPE_MC_CTRL_PERF_EN
  ,
  output logic [31:0]     cycle_cnt_o,
  output logic [31:0]     instret_o
`endif
);

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] ir;
  logic            dec_legal;
  logic [3:0]      dec_alu_op;
  logic            rd_nonzero;

  rtype_decoder u_decoder (
    .instr  (ir),
    .legal  (dec_legal),
    .alu_op (dec_alu_op)
  );

  assign instr_o    = ir;
  assign rd_nonzero = (ir[11:7] != 5'd0);

  // State register; reset drops any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction register: loads only on an accepted fetch, reset wins over ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= '0;
    end else if ((state == ST_FETCH) && imem_ack_i) begin
      ir <= imem_rdata_i;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt    = state;
    imem_req_o   = 1'b0;
    alu_op_o     = ALU_ADD;
    alu_res_we_o = 1'b0;
    reg_wen_o    = 1'b0;
    pc_we_o      = 1'b0;
    illegal_o    = 1'b0;
    busy_o       = 1'b0;
    case (state)
      ST_FETCH: begin
        // Request is masked while reset is held so the rst cycle shows no fetch.
        imem_req_o = ~rst;
        if (imem_ack_i) begin
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        busy_o    = 1'b1;
        state_nxt = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        busy_o       = 1'b1;
        alu_op_o     = dec_alu_op;
        alu_res_we_o = 1'b1;
        state_nxt    = ST_WB;
      end
      ST_WB: begin
        busy_o    = 1'b1;
        reg_wen_o = rd_nonzero;
        pc_we_o   = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_TRAP: begin
        illegal_o = 1'b1;
        state_nxt = ST_TRAP;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

`ifdef RTYPE_MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret;

  assign cycle_cnt_o = cycle_cnt;
  assign instret_o   = instret;

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state == ST_WB) begin
        instret <= instret + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rtype_mc_ctrl.sv
// Self-checking bench for rtype_mc_ctrl: directed scenarios plus random
// R-type and random words, checked cycle by cycle against a reference
// model of the instruction set and phase timeline.
module tb_rtype_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] instr_o;
  logic [3:0]  alu_op_o;
  logic        alu_res_we_o;
  logic        reg_wen_o;
  logic        pc_we_o;
  logic        illegal_o;
  logic        busy_o;
`ifdef RTYPE_MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_o;
  logic [31:0] instret_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc_m = 0;
  int instret_m = 0;

  // ALU op for funct7=0000000 indexed by funct3.
  int base_map [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  always #5 clk = ~clk;

  rtype_mc_ctrl #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .alu_op_o     (alu_op_o),
    .alu_res_we_o (alu_res_we_o),
    .reg_wen_o    (reg_wen_o),
    .pc_we_o      (pc_we_o),
    .illegal_o    (illegal_o),
    .busy_o       (busy_o)
`ifdef RTYPE_MC_CTRL_PERF_EN
    ,
    .cycle_cnt_o  (cycle_cnt_o),
    .instret_o    (instret_o)
`endif
  );

  // Reference cycle count: one per rising edge with reset low.
  always @(posedge clk) begin
    if (rst) cyc_m <= 0;
    else     cyc_m <= cyc_m + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_decode(input logic [31:0] w, output bit legal, output int op);
    int f3;
    int f7;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    legal = 1'b0;
    op = 0;
    if (w[6:0] == 7'h33) begin
      if (f7 == 0) begin
        legal = 1'b1;
        op = base_map[f3];
      end else if (f7 == 32 && f3 == 0) begin
        legal = 1'b1;
        op = 1;
      end else if (f7 == 32 && f3 == 5) begin
        legal = 1'b1;
        op = 7;
      end
    end
  endfunction

  task automatic check_perf(input string tag);
`ifdef RTYPE_MC_CTRL_PERF_EN
    check({tag, "_cyc"}, cycle_cnt_o, cyc_m);
    check({tag, "_instret"}, instret_o, instret_m);
`else
    n_vec = n_vec + 0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack_i = 1'b0;
    step();
    step();
    instret_m = 0;
    check("rst_req", imem_req_o, 0);
    check("rst_ir", instr_o, 0);
    check("rst_outs", {alu_op_o, alu_res_we_o, reg_wen_o, pc_we_o, illegal_o, busy_o}, 0);
    check_perf("rst");
    rst = 1'b0;
    #1;
    check("req_after_rst", imem_req_o, 1);
  endtask

  // Runs one instruction from FETCH; returns trapped=1 if it went to TRAP.
  task automatic run_instr(input logic [31:0] w, input int dly, input bit spur, output bit trapped);
    bit legal;
    int op;
    ref_decode(w, legal, op);
    trapped = 1'b0;
    for (int i = 0; i <= dly; i++) begin
      check("fetch_req", imem_req_o, 1);
      check("fetch_busy", busy_o, 0);
      check("fetch_strb", {alu_res_we_o, reg_wen_o, pc_we_o}, 0);
      imem_ack_i   = (i == dly);
      imem_rdata_i = (i == dly) ? w : $urandom;
      step();
    end
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    check("dec_ir", instr_o, w);
    check("dec_req", imem_req_o, 0);
    check("dec_busy", busy_o, 1);
    check("dec_outs", {alu_op_o, alu_res_we_o, reg_wen_o, pc_we_o, illegal_o}, 0);
    if (!legal) begin
      step();
      for (int k = 0; k < 12; k++) begin
        check("trap_ill", illegal_o, 1);
        check("trap_quiet", {imem_req_o, busy_o, alu_res_we_o, reg_wen_o, pc_we_o, alu_op_o}, 0);
        check("trap_ir", instr_o, w);
        imem_ack_i   = 1'($urandom_range(0, 1));
        imem_rdata_i = $urandom;
        step();
      end
      imem_ack_i = 1'b0;
      trapped = 1'b1;
      return;
    end
    step();
    check("exec_op", alu_op_o, op);
    check("exec_we", alu_res_we_o, 1);
    check("exec_strb", {imem_req_o, reg_wen_o, pc_we_o, illegal_o}, 0);
    if (spur) begin
      imem_ack_i   = 1'b1;
      imem_rdata_i = ~w;
    end
    step();
    imem_ack_i = 1'b0;
    check("wb_ir", instr_o, w);
    check("wb_wen", reg_wen_o, (w[11:7] != 5'd0));
    check("wb_pc", pc_we_o, 1);
    check("wb_quiet", {imem_req_o, alu_res_we_o, alu_op_o, illegal_o}, 0);
    instret_m++;
    step();
    check("next_req", imem_req_o, 1);
    check("next_ir", instr_o, w);
    check_perf("retire");
  endtask

  initial begin
    bit tr;
    logic [31:0] w;
    int f3;
    bit alt;

    do_reset();

    run_instr(32'h002081B3, 0, 1'b0, tr);
    run_instr(32'h407302B3, 0, 1'b0, tr);
    run_instr(32'h00208033, 0, 1'b0, tr);
    run_instr(32'h4020D233, 3, 1'b1, tr);
    run_instr(32'h00000013, 0, 1'b0, tr);
    check("addi_trapped", tr, 1);
    do_reset();

    // Reset during EXEC drops the writeback.
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h003100B3;
    step();
    imem_ack_i = 1'b0;
    step();
    check("pre_rst_exec", alu_res_we_o, 1);
    rst = 1'b1;
    step();
    instret_m = 0;
    check("rexec_wen", reg_wen_o, 0);
    check("rexec_pc", pc_we_o, 0);
    check("rexec_ir", instr_o, 0);
    check("rexec_req", imem_req_o, 0);
    check_perf("rexec");
    rst = 1'b0;
    #1;
    check("rexec_req_after", imem_req_o, 1);
    step();
    check("rexec_wen_later", reg_wen_o, 0);
    check("rexec_idle_req", imem_req_o, 1);
    check_perf("rexec_restart");

    // Reset wins over an ack in the same cycle.
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h002081B3;
    rst = 1'b1;
    step();
    imem_ack_i = 1'b0;
    check("rack_ir", instr_o, 0);
    rst = 1'b0;
    #1;
    check("rack_req", imem_req_o, 1);
    step();
    check("rack_ir_after", instr_o, 0);
    check("rack_busy", busy_o, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        f3  = $urandom_range(0, 7);
        alt = 1'($urandom_range(0, 1)) && (f3 == 0 || f3 == 5);
        w = {alt ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom), 3'(f3), 5'($urandom), 7'h33};
      end else begin
        w = $urandom;
      end
      run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), tr);
      if (tr) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
